decode_stage: RTL and testbench
===============================

# decode_stage

Registered instruction-decode pipeline stage between fetch and execute, succeeding the combinational control decoder. It decodes RV32I/RV64I with optional M extension and classifies illegal encodings. Decoded control is registered behind a valid/ready handshake on both sides. It inserts one load-use bubble and supports a synchronous flush from branch/jump resolution.

## Interface
- XLEN, 32: 32 or 64. At 64, OP-IMM-32/OP-32, LD/LWU/SD and 6-bit shamt are legal.
- M_EXT, 1: 1 decodes MUL/DIV/REM (fn7=0000001) as legal; 0 flags them illegal.
- clk  in  1  clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- flush  in  1  kill stage contents; highest priority
- in_valid  in  1  fetch offers in_inst/in_pc
- in_ready  out  1  stage accepts this cycle
- in_inst  in  32  instruction word
- in_pc  in  XLEN  instruction address
- out_valid  out  1  out_* fields hold a decoded instruction
- out_ready  in  1  execute consumes this cycle
- out_ctrl  out  CTRL_W  packed control: alu_op[2:0], alu_imm, alu_sub, alu_sra, alu_w, md, rd_w, ld_upper, add_pc, jmp_reg, is_branch, is_jmp, is_load, is_store, is_fence, is_system, illegal
- out_rd, out_rs1, out_rs2  out  5 each  register indices
- out_pc  out  XLEN  registered in_pc
- out_inst  out  32  registered in_inst

## Operation
- Decode, base ISA:
  - alu_op = fn3, except 000 for jal/jalr/load/store.
  - alu_imm for I and S types.
  - alu_sub for OP (and OP-32) with fn3=000, fn7=0100000.
  - alu_sra for shift-right with fn7[6:1]=010000 (XLEN 64) or fn7=0100000 (XLEN 32).
  - rd_w for R/I/U/J types.
- alu_w: OP-IMM-32/OP-32 (XLEN 64 only).
- md: M-extension op; alu_op then carries the M fn3.
- is_fence: MISC-MEM opcode. is_system: SYSTEM opcode.
- illegal set for any of:
  - unknown opcode;
  - OP/OP-32 fn7 not 0000000, 0100000 (ADD/SUB/SRL/SRA only) or 0000001 (M_EXT=1);
  - bad shift fn7/fn6;
  - branch fn3 010/011;
  - jalr fn3≠000;
  - load fn3 111, or 011/110 when XLEN 32;
  - store fn3 ≥100, or 011 when XLEN 32;
  - any 64-bit-only opcode when XLEN 32.
- When illegal is set: rd_w, is_load, is_store, is_branch, is_jmp and md are forced 0. The instruction still propagates.
- Handshake:
  - in_ready = !flush && !hazard && (!out_valid || out_ready).
  - Accept when in_valid && in_ready: register load, out_valid←1.
  - Else if out_ready: out_valid←0.
  - Else hold all out_* unchanged.
- hazard = out_valid && ctrl.is_load && out_rd≠0 && ((uses_rs1 && rs1==out_rd) || (uses_rs2 && rs2==out_rd)).
  - uses_rs1: R, I, S, B types.
  - uses_rs2: R, S, B types.
- flush: out_valid←0 at the next edge regardless of out_ready; in_ready=0 that cycle; the fetch word is dropped.

## Timing
- Latency 1 cycle from accept to out_valid. Throughput 1/cycle with out_ready held high.
- out_* driven only from registers; no combinational in→out path. in_ready depends combinationally on flush, out_ready and in_inst.
- Reset: out_valid=0, out_ctrl=0, out_rd/rs1/rs2=0, out_pc=0, out_inst=0. in_ready=1 once rst_n deasserts with flush=0.
- Load-use produces exactly one bubble: load handed off at cycle N; dependent accepted at N+1; out_valid=0 during N+1.
- Simultaneous flush and accept: flush wins, nothing is registered.
- Reset mid-stall: all state clears asynchronously; no pending hazard survives.
- out_* stable while out_valid && !out_ready.

## Structure
- ctrl_pkg holds:
  - opcode localparams;
  - ctrl_t packed struct and CTRL_W;
  - fn7 constants (BASE, ALT, MULDIV).
- Sub-module ctrl_decode: purely combinational inst→ctrl_t, rd, rs1, rs2, uses_rs1, uses_rs2. Parameterised by XLEN and M_EXT.
- decode_stage contains the handshake, hazard check and output register.

## Test plan
- Reset, then 0x002081B3 (ADD x3,x1,x2) at pc 0x100 → next cycle out_valid=1, alu_op=000, alu_sub=0, rd_w=1, out_rd=3, out_pc=0x100. Repeat with 0x402081B3 → alu_sub=1.
- 0x0000A283 (LW x5,0(x1)) then 0x00028333 (ADD x6,x5,x0), out_ready=1 → in_ready=0 one cycle, one bubble, ADD issued next cycle. Same with rd=x0 → no bubble.
- M_EXT=1: 0x022081B3 → md=1, alu_op=000, illegal=0. M_EXT=0: same word → illegal=1, rd_w=0.
- 0x002081BB (ADDW): XLEN=64 → alu_w=1, legal; XLEN=32 → illegal=1. 0x00000000 → illegal=1 in both.
- out_ready=0 for 3 cycles with valid ADD held → out_* stable, in_ready=0. Then out_ready=1 → drain and accept same cycle.
- flush asserted with in_valid=1 and out_valid=1 → out_valid=0 next cycle, fetched word not registered. Also assert rst_n low mid-stall → all outputs 0 immediately.

Source files
------------

// File: rtl/ctrl_pkg.sv
// Shared decode definitions: RISC-V opcodes, function-field constants and the
// packed control word handed from decode to execute.
package ctrl_pkg;

  // Major opcodes (inst[6:0])
  localparam logic [6:0] OPC_LOAD      = 7'b0000011;
  localparam logic [6:0] OPC_MISC_MEM  = 7'b0001111;
  localparam logic [6:0] OPC_OP_IMM    = 7'b0010011;
  localparam logic [6:0] OPC_AUIPC     = 7'b0010111;
  localparam logic [6:0] OPC_OP_IMM_32 = 7'b0011011;
  localparam logic [6:0] OPC_STORE     = 7'b0100011;
  localparam logic [6:0] OPC_OP        = 7'b0110011;
  localparam logic [6:0] OPC_LUI       = 7'b0110111;
  localparam logic [6:0] OPC_OP_32     = 7'b0111011;
  localparam logic [6:0] OPC_BRANCH    = 7'b1100011;
  localparam logic [6:0] OPC_JALR      = 7'b1100111;
  localparam logic [6:0] OPC_JAL       = 7'b1101111;
  localparam logic [6:0] OPC_SYSTEM    = 7'b1110011;

  // fn7 encodings for register-register ops and 32-bit shifts
  localparam logic [6:0] FN7_BASE   = 7'b0000000;
  localparam logic [6:0] FN7_ALT    = 7'b0100000;
  localparam logic [6:0] FN7_MULDIV = 7'b0000001;

  // fn6 encodings for 64-bit immediate shifts (shamt[5] lives in inst[25])
  localparam logic [5:0] FN6_BASE = 6'b000000;
  localparam logic [5:0] FN6_ALT  = 6'b010000;

  // Decoded control word; first field is the MSB.
  typedef struct packed {
    logic [2:0] alu_op;
    logic       alu_imm;
    logic       alu_sub;
    logic       alu_sra;
    logic       alu_w;
    logic       md;
    logic       rd_w;
    logic       ld_upper;
    logic       add_pc;
    logic       jmp_reg;
    logic       is_branch;
    logic       is_jmp;
    logic       is_load;
    logic       is_store;
    logic       is_fence;
    logic       is_system;
    logic       illegal;
  } ctrl_t;

  localparam int CTRL_W = $bits(ctrl_t);

endpackage

// File: rtl/ctrl_decode.sv
// Combinational RV32I/RV64I(+M) decoder: instruction word to control word,
// register indices and source-operand usage flags for hazard detection.
module ctrl_decode
  import ctrl_pkg::*;
#(
  parameter int XLEN  = 32,
  parameter bit M_EXT = 1'b1
) (
  input  logic [31:0] inst_i,
  output ctrl_t       ctrl_o,
  output logic [4:0]  rd_o,
  output logic [4:0]  rs1_o,
  output logic [4:0]  rs2_o,
  output logic        uses_rs1_o,
  output logic        uses_rs2_o
);

  localparam bit RV64 = (XLEN == 64);

  logic [6:0] opcode;
  logic [2:0] fn3;
  logic [6:0] fn7;
  ctrl_t      dec;
  logic       bad;
  logic       fmt_r, fmt_i, fmt_s, fmt_b;

  assign opcode = inst_i[6:0];
  assign fn3    = inst_i[14:12];
  assign fn7    = inst_i[31:25];
  assign rd_o   = inst_i[11:7];
  assign rs1_o  = inst_i[19:15];
  assign rs2_o  = inst_i[24:20];

  // Opcode-driven decode, illegal classification and masking of side effects
  // NOTE: every signal written here gets a default first, so no path leaves
  // one unassigned and no latch is inferred.
  always_comb begin
    dec        = '0;
    dec.alu_op = fn3;
    bad        = 1'b0;
    fmt_r      = 1'b0;
    fmt_i      = 1'b0;
    fmt_s      = 1'b0;
    fmt_b      = 1'b0;

    unique case (opcode)
      OPC_LOAD: begin
        fmt_i       = 1'b1;
        dec.alu_op  = 3'b000;
        dec.alu_imm = 1'b1;
        dec.rd_w    = 1'b1;
        dec.is_load = 1'b1;
        bad = (fn3 == 3'b111) || (!RV64 && (fn3 == 3'b011 || fn3 == 3'b110));
      end
      OPC_MISC_MEM: dec.is_fence = 1'b1;
      OPC_OP_IMM: begin
        fmt_i       = 1'b1;
        dec.alu_imm = 1'b1;
        dec.rd_w    = 1'b1;
        if (fn3 == 3'b001) begin
          bad = RV64 ? (fn7[6:1] != FN6_BASE) : (fn7 != FN7_BASE);
        end else if (fn3 == 3'b101) begin
          if (RV64) begin
            dec.alu_sra = (fn7[6:1] == FN6_ALT);
            bad         = (fn7[6:1] != FN6_BASE) && (fn7[6:1] != FN6_ALT);
          end else begin
            dec.alu_sra = (fn7 == FN7_ALT);
            bad         = (fn7 != FN7_BASE) && (fn7 != FN7_ALT);
          end
        end
      end
      OPC_OP_IMM_32: begin
        fmt_i       = 1'b1;
        dec.alu_imm = 1'b1;
        dec.alu_w   = RV64;
        dec.rd_w    = 1'b1;
        bad         = !RV64;
        if (fn3 == 3'b001) begin
          bad = bad || (fn7 != FN7_BASE);
        end else if (fn3 == 3'b101) begin
          dec.alu_sra = (fn7 == FN7_ALT);
          bad         = bad || ((fn7 != FN7_BASE) && (fn7 != FN7_ALT));
        end
      end
      OPC_OP, OPC_OP_32: begin
        fmt_r    = 1'b1;
        dec.rd_w = 1'b1;
        if (opcode == OPC_OP_32) begin
          dec.alu_w = RV64;
          bad       = !RV64;
        end
        if (M_EXT && fn7 == FN7_MULDIV) begin
          dec.md = 1'b1;
        end else if (fn7 == FN7_ALT && (fn3 == 3'b000 || fn3 == 3'b101)) begin
          dec.alu_sub = (fn3 == 3'b000);
          dec.alu_sra = (fn3 == 3'b101);
        end else if (fn7 != FN7_BASE) begin
          bad = 1'b1;
        end
      end
      OPC_AUIPC: begin
        dec.add_pc = 1'b1;
        dec.rd_w   = 1'b1;
      end
      OPC_LUI: begin
        dec.ld_upper = 1'b1;
        dec.rd_w     = 1'b1;
      end
      OPC_STORE: begin
        fmt_s        = 1'b1;
        dec.alu_op   = 3'b000;
        dec.alu_imm  = 1'b1;
        dec.is_store = 1'b1;
        bad = fn3[2] || (!RV64 && fn3 == 3'b011);
      end
      OPC_BRANCH: begin
        fmt_b         = 1'b1;
        dec.is_branch = 1'b1;
        bad = (fn3 == 3'b010) || (fn3 == 3'b011);
      end
      OPC_JALR: begin
        fmt_i       = 1'b1;
        dec.alu_op  = 3'b000;
        dec.alu_imm = 1'b1;
        dec.rd_w    = 1'b1;
        dec.is_jmp  = 1'b1;
        dec.jmp_reg = 1'b1;
        bad         = (fn3 != 3'b000);
      end
      OPC_JAL: begin
        dec.alu_op = 3'b000;
        dec.rd_w   = 1'b1;
        dec.is_jmp = 1'b1;
      end
      OPC_SYSTEM: dec.is_system = 1'b1;
      default: bad = 1'b1;
    endcase

    // An illegal word still flows down the pipe, but with no architectural
    // side effects so execute can raise the exception cleanly.
    dec.illegal = bad;
    if (bad) begin
      dec.rd_w      = 1'b0;
      dec.is_load   = 1'b0;
      dec.is_store  = 1'b0;
      dec.is_branch = 1'b0;
      dec.is_jmp    = 1'b0;
      dec.md        = 1'b0;
    end
  end

  assign ctrl_o     = dec;
  assign uses_rs1_o = fmt_r || fmt_i || fmt_s || fmt_b;
  assign uses_rs2_o = fmt_r || fmt_s || fmt_b;

endmodule

// File: rtl/decode_stage.sv
// Registered decode stage: valid/ready handshake on both sides, one-bubble
// load-use interlock and a flush that kills the stage contents.
module decode_stage
  import ctrl_pkg::*;
#(
  parameter int XLEN  = 32,
  parameter bit M_EXT = 1'b1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [31:0]       in_inst,
  input  logic [XLEN-1:0]   in_pc,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [CTRL_W-1:0] out_ctrl,
  output logic [4:0]        out_rd,
  output logic [4:0]        out_rs1,
  output logic [4:0]        out_rs2,
  output logic [XLEN-1:0]   out_pc,
  output logic [31:0]       out_inst
);

  ctrl_t      dec_ctrl;
  logic [4:0] dec_rd, dec_rs1, dec_rs2;
  logic       dec_uses_rs1, dec_uses_rs2;

  logic            valid_q, valid_d;
  ctrl_t           ctrl_q;
  logic [4:0]      rd_q, rs1_q, rs2_q;
  logic [XLEN-1:0] pc_q;
  logic [31:0]     inst_q;
  logic            hazard, accept;

  ctrl_decode #(
    .XLEN  (XLEN),
    .M_EXT (M_EXT)
  ) u_dec (
    .inst_i     (in_inst),
    .ctrl_o     (dec_ctrl),
    .rd_o       (dec_rd),
    .rs1_o      (dec_rs1),
    .rs2_o      (dec_rs2),
    .uses_rs1_o (dec_uses_rs1),
    .uses_rs2_o (dec_uses_rs2)
  );

  // Load-use interlock, input handshake and next valid state
  // NOTE: combinational logic uses blocking '=' so later lines see the values
  // computed above them in the same evaluation.
  always_comb begin
    hazard = valid_q && ctrl_q.is_load && (rd_q != 5'd0) &&
             ((dec_uses_rs1 && dec_rs1 == rd_q) ||
              (dec_uses_rs2 && dec_rs2 == rd_q));
    in_ready = !flush && !hazard && (!valid_q || out_ready);
    accept   = in_valid && in_ready;
    valid_d  = valid_q;
    if (flush) begin
      valid_d = 1'b0;
    end else if (accept) begin
      valid_d = 1'b1;
    end else if (out_ready) begin
      valid_d = 1'b0;
    end
  end

  // Output register: loads on accept, otherwise holds
  // NOTE: sequential state uses non-blocking '<=' so every register samples
  // pre-edge values. Payload registers are reset as well because the
  // outputs must read zero while in reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= 1'b0;
      ctrl_q  <= '0;
      rd_q    <= '0;
      rs1_q   <= '0;
      rs2_q   <= '0;
      pc_q    <= '0;
      inst_q  <= '0;
    end else begin
      valid_q <= valid_d;
      if (accept) begin
        ctrl_q <= dec_ctrl;
        rd_q   <= dec_rd;
        rs1_q  <= dec_rs1;
        rs2_q  <= dec_rs2;
        pc_q   <= in_pc;
        inst_q <= in_inst;
      end
    end
  end

  assign out_valid = valid_q;
  assign out_ctrl  = ctrl_q;
  assign out_rd    = rd_q;
  assign out_rs1   = rs1_q;
  assign out_rs2   = rs2_q;
  assign out_pc    = pc_q;
  assign out_inst  = inst_q;

endmodule

// File: tb/tb_decode_stage.sv
// Directed bench for decode_stage. Three instances share one stimulus:
// a = XLEN32/M, b = XLEN64/M, c = XLEN32 without M.
module tb_decode_stage;
  import ctrl_pkg::*;

  localparam logic [31:0] I_ADD   = 32'h002081B3; // add x3,x1,x2
  localparam logic [31:0] I_SUB   = 32'h402081B3; // sub x3,x1,x2
  localparam logic [31:0] I_LW    = 32'h0000A283; // lw x5,0(x1)
  localparam logic [31:0] I_LW0   = 32'h0000A003; // lw x0,0(x1)
  localparam logic [31:0] I_DEP   = 32'h00028333; // add x6,x5,x0

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        flush = 1'b0;
  logic        in_valid = 1'b0;
  logic [31:0] in_inst = '0;
  logic [63:0] in_pc = '0;
  logic        out_ready = 1'b0;

  logic              in_ready_a, in_ready_b, in_ready_c;
  logic              out_valid_a, out_valid_b, out_valid_c;
  logic [CTRL_W-1:0] out_ctrl_a, out_ctrl_b, out_ctrl_c;
  logic [4:0]        out_rd_a, out_rs1_a, out_rs2_a;
  logic [4:0]        out_rd_b, out_rs1_b, out_rs2_b;
  logic [4:0]        out_rd_c, out_rs1_c, out_rs2_c;
  logic [31:0]       out_pc_a, out_pc_c;
  logic [63:0]       out_pc_b;
  logic [31:0]       out_inst_a, out_inst_b, out_inst_c;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  decode_stage #(.XLEN(32), .M_EXT(1'b1)) dut_a (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready_a), .in_inst(in_inst), .in_pc(in_pc[31:0]),
    .out_valid(out_valid_a), .out_ready(out_ready), .out_ctrl(out_ctrl_a),
    .out_rd(out_rd_a), .out_rs1(out_rs1_a), .out_rs2(out_rs2_a),
    .out_pc(out_pc_a), .out_inst(out_inst_a)
  );

  decode_stage #(.XLEN(64), .M_EXT(1'b1)) dut_b (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready_b), .in_inst(in_inst), .in_pc(in_pc),
    .out_valid(out_valid_b), .out_ready(out_ready), .out_ctrl(out_ctrl_b),
    .out_rd(out_rd_b), .out_rs1(out_rs1_b), .out_rs2(out_rs2_b),
    .out_pc(out_pc_b), .out_inst(out_inst_b)
  );

  decode_stage #(.XLEN(32), .M_EXT(1'b0)) dut_c (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready_c), .in_inst(in_inst), .in_pc(in_pc[31:0]),
    .out_valid(out_valid_c), .out_ready(out_ready), .out_ctrl(out_ctrl_c),
    .out_rd(out_rd_c), .out_rs1(out_rs1_c), .out_rs2(out_rs2_c),
    .out_pc(out_pc_c), .out_inst(out_inst_c)
  );

  // Advance one clock and land 1 ns after the edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    step();
    step();
    total++; if (out_valid_a !== 1'b0) begin bad++; $display("FAIL reset_valid: got %b want 0", out_valid_a); end
    total++; if (out_ctrl_a !== '0) begin bad++; $display("FAIL reset_ctrl: got %h want 0", out_ctrl_a); end
    total++; if ({out_rd_a, out_rs1_a, out_rs2_a} !== 15'd0) begin bad++; $display("FAIL reset_regs: got %h want 0", {out_rd_a, out_rs1_a, out_rs2_a}); end
    total++; if (out_pc_b !== 64'd0 || out_inst_a !== 32'd0) begin bad++; $display("FAIL reset_pc_inst: got %h/%h want 0/0", out_pc_b, out_inst_a); end
    rst_n = 1'b1;
    #1;
    total++; if (in_ready_a !== 1'b1) begin bad++; $display("FAIL reset_in_ready: got %b want 1", in_ready_a); end
  endtask

  task automatic test_add_sub();
    ctrl_t c;
    out_ready = 1'b1;
    in_valid  = 1'b1;
    in_inst   = I_ADD;
    in_pc     = 64'h100;
    step();
    c = out_ctrl_a;
    total++; if (out_valid_a !== 1'b1) begin bad++; $display("FAIL add_valid: got %b want 1", out_valid_a); end
    total++; if (c.alu_op !== 3'b000 || c.alu_sub !== 1'b0 || c.rd_w !== 1'b1) begin bad++; $display("FAIL add_ctrl: got %h want 00400", out_ctrl_a); end
    total++; if (out_rd_a !== 5'd3 || out_rs1_a !== 5'd1 || out_rs2_a !== 5'd2) begin bad++; $display("FAIL add_regs: got %0d/%0d/%0d want 3/1/2", out_rd_a, out_rs1_a, out_rs2_a); end
    total++; if (out_pc_a !== 32'h100 || out_inst_a !== I_ADD) begin bad++; $display("FAIL add_pc_inst: got %h/%h want 100/%h", out_pc_a, out_inst_a, I_ADD); end
    in_inst = I_SUB;
    in_pc   = 64'h104;
    step();
    c = out_ctrl_a;
    total++; if (out_valid_a !== 1'b1 || c.alu_sub !== 1'b1 || out_ctrl_a !== 19'h04400) begin bad++; $display("FAIL sub_ctrl: got v=%b %h want v=1 04400", out_valid_a, out_ctrl_a); end
    total++; if (out_pc_a !== 32'h104) begin bad++; $display("FAIL sub_pc: got %h want 104", out_pc_a); end
    in_valid = 1'b0;
    step();
    total++; if (out_valid_a !== 1'b0) begin bad++; $display("FAIL drain_valid: got %b want 0", out_valid_a); end
  endtask

  task automatic test_decode_table();
    logic [31:0] v_inst [14];
    logic [18:0] v_a [14];
    logic [18:0] v_b [14];
    logic [18:0] v_c [14];
    v_inst = '{32'h002081B3, 32'h402081B3, 32'h022081B3, 32'h002081BB, 32'h00000000,
               32'h00208463, 32'h0020A463, 32'h000100E7, 32'h40315093, 32'h42315093,
               32'h0020A023, 32'h0000000F, 32'h00000073, 32'h0000B283};
    v_a    = '{19'h00400, 19'h04400, 19'h00C00, 19'h00001, 19'h00001,
               19'h00040, 19'h20001, 19'h084A0, 19'h5A400, 19'h58001,
               19'h08008, 19'h00004, 19'h00002, 19'h08001};
    v_b    = '{19'h00400, 19'h04400, 19'h00C00, 19'h01400, 19'h00001,
               19'h00040, 19'h20001, 19'h084A0, 19'h5A400, 19'h5A400,
               19'h08008, 19'h00004, 19'h00002, 19'h08410};
    v_c    = '{19'h00400, 19'h04400, 19'h00001, 19'h00001, 19'h00001,
               19'h00040, 19'h20001, 19'h084A0, 19'h5A400, 19'h58001,
               19'h08008, 19'h00004, 19'h00002, 19'h08001};
    out_ready = 1'b1;
    in_valid  = 1'b1;
    for (int i = 0; i < 14; i++) begin
      in_inst = v_inst[i];
      in_pc   = 64'h1000 + 64'(i * 4);
      step();
      total++; if (out_valid_a !== 1'b1 || out_inst_a !== v_inst[i]) begin bad++; $display("FAIL dec_valid[%0d]: got v=%b %h want v=1 %h", i, out_valid_a, out_inst_a, v_inst[i]); end
      total++; if (out_ctrl_a !== v_a[i]) begin bad++; $display("FAIL dec_x32[%0d] %h: got %h want %h", i, v_inst[i], out_ctrl_a, v_a[i]); end
      total++; if (out_ctrl_b !== v_b[i]) begin bad++; $display("FAIL dec_x64[%0d] %h: got %h want %h", i, v_inst[i], out_ctrl_b, v_b[i]); end
      total++; if (out_ctrl_c !== v_c[i]) begin bad++; $display("FAIL dec_nom[%0d] %h: got %h want %h", i, v_inst[i], out_ctrl_c, v_c[i]); end
    end
    in_valid = 1'b0;
    step();
  endtask

  task automatic test_load_use();
    out_ready = 1'b1;
    in_valid  = 1'b1;
    in_inst   = I_LW;
    in_pc     = 64'h300;
    step();
    total++; if (out_valid_a !== 1'b1 || out_ctrl_a !== 19'h08410) begin bad++; $display("FAIL lw_out: got v=%b %h want v=1 08410", out_valid_a, out_ctrl_a); end
    in_inst = I_DEP;
    in_pc   = 64'h304;
    #1;
    total++; if (in_ready_a !== 1'b0) begin bad++; $display("FAIL lu_stall_ready: got %b want 0", in_ready_a); end
    step();
    total++; if (out_valid_a !== 1'b0) begin bad++; $display("FAIL lu_bubble: got %b want 0", out_valid_a); end
    total++; if (in_ready_a !== 1'b1) begin bad++; $display("FAIL lu_resume_ready: got %b want 1", in_ready_a); end
    step();
    total++; if (out_valid_a !== 1'b1 || out_inst_a !== I_DEP || out_rd_a !== 5'd6 || out_pc_a !== 32'h304) begin bad++; $display("FAIL lu_dep_issue: got v=%b %h rd=%0d pc=%h want v=1 %h rd=6 pc=304", out_valid_a, out_inst_a, out_rd_a, out_pc_a, I_DEP); end
    // Load to x0 never interlocks.
    in_inst = I_LW0;
    step();
    in_inst = I_DEP;
    #1;
    total++; if (in_ready_a !== 1'b1) begin bad++; $display("FAIL lw0_ready: got %b want 1", in_ready_a); end
    step();
    total++; if (out_valid_a !== 1'b1 || out_inst_a !== I_DEP) begin bad++; $display("FAIL lw0_no_bubble: got v=%b %h want v=1 %h", out_valid_a, out_inst_a, I_DEP); end
    in_valid = 1'b0;
    step();
  endtask

  task automatic test_stall();
    out_ready = 1'b1;
    in_valid  = 1'b1;
    in_inst   = I_ADD;
    in_pc     = 64'h400;
    step();
    out_ready = 1'b0;
    in_inst   = I_SUB;
    in_pc     = 64'h404;
    for (int i = 0; i < 3; i++) begin
      #1;
      total++; if (in_ready_a !== 1'b0) begin bad++; $display("FAIL stall_ready[%0d]: got %b want 0", i, in_ready_a); end
      step();
      total++; if (out_valid_a !== 1'b1 || out_inst_a !== I_ADD || out_ctrl_a !== 19'h00400 || out_pc_a !== 32'h400) begin bad++; $display("FAIL stall_hold[%0d]: got v=%b %h %h pc=%h want v=1 %h 00400 pc=400", i, out_valid_a, out_inst_a, out_ctrl_a, out_pc_a, I_ADD); end
    end
    out_ready = 1'b1;
    #1;
    total++; if (in_ready_a !== 1'b1) begin bad++; $display("FAIL stall_release_ready: got %b want 1", in_ready_a); end
    step();
    total++; if (out_valid_a !== 1'b1 || out_inst_a !== I_SUB || out_pc_a !== 32'h404) begin bad++; $display("FAIL stall_drain_accept: got v=%b %h pc=%h want v=1 %h pc=404", out_valid_a, out_inst_a, out_pc_a, I_SUB); end
    in_valid = 1'b0;
    step();
  endtask

  task automatic test_flush();
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_inst   = I_ADD;
    in_pc     = 64'h200;
    step();
    flush   = 1'b1;
    in_inst = I_SUB;
    in_pc   = 64'h204;
    #1;
    total++; if (in_ready_a !== 1'b0) begin bad++; $display("FAIL flush_ready: got %b want 0", in_ready_a); end
    step();
    total++; if (out_valid_a !== 1'b0 || out_valid_b !== 1'b0) begin bad++; $display("FAIL flush_kill: got %b/%b want 0/0", out_valid_a, out_valid_b); end
    flush    = 1'b0;
    in_valid = 1'b0;
    step();
    total++; if (out_valid_a !== 1'b0 || out_inst_a !== I_ADD || out_pc_a !== 32'h200) begin bad++; $display("FAIL flush_dropped: got v=%b %h pc=%h want v=0 %h pc=200", out_valid_a, out_inst_a, out_pc_a, I_ADD); end
  endtask

  task automatic test_reset_mid_stall();
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_inst   = I_LW;
    in_pc     = 64'h500;
    step();
    in_inst = I_DEP;
    in_pc   = 64'h504;
    step();
    total++; if (out_valid_a !== 1'b1 || out_inst_a !== I_LW || in_ready_a !== 1'b0) begin bad++; $display("FAIL rst_pre_stall: got v=%b %h rdy=%b want v=1 %h rdy=0", out_valid_a, out_inst_a, in_ready_a, I_LW); end
    #2;
    rst_n = 1'b0;
    #1;
    total++; if (out_valid_a !== 1'b0 || out_ctrl_a !== '0 || out_rd_a !== 5'd0) begin bad++; $display("FAIL rst_async_state: got v=%b %h rd=%0d want 0", out_valid_a, out_ctrl_a, out_rd_a); end
    total++; if (out_pc_a !== 32'd0 || out_inst_a !== 32'd0) begin bad++; $display("FAIL rst_async_data: got %h/%h want 0/0", out_pc_a, out_inst_a); end
    total++; if (in_ready_a !== 1'b1) begin bad++; $display("FAIL rst_no_hazard: got %b want 1", in_ready_a); end
    in_valid = 1'b0;
    step();
    rst_n = 1'b1;
    step();
    total++; if (out_valid_a !== 1'b0 || in_ready_a !== 1'b1) begin bad++; $display("FAIL rst_after: got v=%b rdy=%b want 0/1", out_valid_a, in_ready_a); end
  endtask

  initial begin
    test_reset();
    test_add_sub();
    test_decode_table();
    test_load_use();
    test_stall();
    test_flush();
    test_reset_mid_stall();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

endmodule
